// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer shared definitions.
// Opcodes, FSM states and field sign extenders.
package pc_sequencer_pkg;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [31:0] sext17(
    input logic [16:0] v
  );
    return {{15{v[16]}}, v};
  endfunction

  function automatic logic [31:0] sext27(
    input logic [26:0] v
  );
    return {{5{v[26]}}, v};
  endfunction

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// Control-transfer target computation.
// Purely combinational; one target per opcode class.
module pc_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [4:0]        i_opcode,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [16:0]       i_imm17,
  input  logic [26:0]       i_target27,
  input  logic [31:0]       i_rd_val,
  output logic [ADDR_W-1:0] o_target
);

  logic [31:0] w_imm_sext;
  logic [31:0] w_tgt_sext;
  logic [31:0] w_pc_ext;
  logic [31:0] w_br_sum;

  assign w_imm_sext = sext17(i_imm17);
  assign w_tgt_sext = sext27(i_target27);
  assign w_pc_ext   = {{(32-ADDR_W){1'b0}}, i_pc};
  // Branch adder is 32 bits wide; truncation gives mod 2^ADDR_W wrap.
  assign w_br_sum   = w_pc_ext + 32'd1 + w_imm_sext;

  // Upper bits above the PC width are dropped by design.
  logic w_unused;
  assign w_unused = ^{i_rd_val[31:ADDR_W],
                      w_br_sum[31:ADDR_W],
                      w_tgt_sext[31:ADDR_W]};

  // Select target by transfer class.
  always_comb begin
    o_target = w_tgt_sext[ADDR_W-1:0];
    case (i_opcode)
      OP_BNE, OP_BLT: o_target = w_br_sum[ADDR_W-1:0];
      OP_JR:          o_target = i_rd_val[ADDR_W-1:0];
      default:        o_target = w_tgt_sext[ADDR_W-1:0];
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: PC register, redirect resolution,
// squash window after taken transfers, redirect counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int FLUSH_CYCLES = 2,
  parameter int TCNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opcode,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [16:0]       ex_imm17,
  input  logic [26:0]       ex_target27,
  input  logic              ex_ne,
  input  logic              ex_lt,
  input  logic [31:0]       ex_rd_val,
  input  logic              ex_rstatus_nz,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic [TCNT_W-1:0] taken_count
);

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [TCNT_W-1:0]   r_taken_count;
  logic                w_bump;
  logic                w_cond;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_target;

  pc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_calc (
    .i_opcode   (ex_opcode),
    .i_pc       (ex_pc),
    .i_imm17    (ex_imm17),
    .i_target27 (ex_target27),
    .i_rd_val   (ex_rd_val),
    .o_target   (w_target)
  );

  // Decode whether the execute-stage instruction transfers control.
  always_comb begin
    w_cond = 1'b0;
    case (ex_opcode)
      OP_J, OP_JAL, OP_JR: w_cond = 1'b1;
      OP_BNE:              w_cond = ex_ne;
      OP_BLT:              w_cond = ex_lt;
      OP_BEX:              w_cond = ex_rstatus_nz;
      default:             w_cond = 1'b0;
    endcase
  end

  assign w_taken = ex_valid & w_cond;

  // Next-state: redirect beats stall; flush window ignores inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc;
    w_bump      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_taken) begin
          w_pc_nxt    = w_target;
          w_cnt_nxt   = FC;
          w_bump      = 1'b1;
          w_state_nxt = FLUSH;
        end else if (!stall) begin
          w_pc_nxt = r_pc + ADDR_W'(1);
        end
      end
      FLUSH: begin
        w_pc_nxt = r_pc + ADDR_W'(1);
        if (r_cnt <= 3'd1) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State, PC and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= RUN;
      r_cnt         <= 3'd0;
      r_pc          <= '0;
      r_taken_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      if (w_bump && (r_taken_count != '1)) begin
        r_taken_count <= r_taken_count + TCNT_W'(1);
      end
    end
  end

  assign pc          = r_pc;
  assign flush       = (r_state == FLUSH);
  assign taken_count = r_taken_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// A narrow-counter instance exercises saturation.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [11:0] ex_pc;
  logic [16:0] ex_imm17;
  logic [26:0] ex_target27;
  logic        ex_ne;
  logic        ex_lt;
  logic [31:0] ex_rd_val;
  logic        ex_rstatus_nz;
  logic [11:0] pc;
  logic        flush;
  logic [15:0] taken_count;
  logic [11:0] s_pc;
  logic        s_flush;
  logic [3:0]  s_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pc_sequencer #(
    .ADDR_W(12), .FLUSH_CYCLES(2), .TCNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_pc(ex_pc), .ex_imm17(ex_imm17),
    .ex_target27(ex_target27), .ex_ne(ex_ne),
    .ex_lt(ex_lt), .ex_rd_val(ex_rd_val),
    .ex_rstatus_nz(ex_rstatus_nz),
    .pc(pc), .flush(flush), .taken_count(taken_count)
  );

  pc_sequencer #(
    .ADDR_W(12), .FLUSH_CYCLES(2), .TCNT_W(4)
  ) dut_s (
    .clock(clock), .reset(reset), .stall(stall),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_pc(ex_pc), .ex_imm17(ex_imm17),
    .ex_target27(ex_target27), .ex_ne(ex_ne),
    .ex_lt(ex_lt), .ex_rd_val(ex_rd_val),
    .ex_rstatus_nz(ex_rstatus_nz),
    .pc(s_pc), .flush(s_flush), .taken_count(s_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag,
                      input logic [11:0] epc,
                      input logic efl,
                      input logic [15:0] etc);
    chk({tag, ".pc"}, 32'(pc), 32'(epc));
    chk({tag, ".flush"}, 32'(flush), 32'(efl));
    chk({tag, ".tc"}, 32'(taken_count), 32'(etc));
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    ex_opcode     = 5'b00000;
    ex_pc         = 12'h000;
    ex_imm17      = 17'h0;
    ex_target27   = 27'h0;
    ex_ne         = 1'b0;
    ex_lt         = 1'b0;
    ex_rd_val     = 32'h0;
    ex_rstatus_nz = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    idle();
    step();
    step();
    chk3("reset", 12'h000, 1'b0, 16'd0);
    reset = 1'b0;

    step(); chk3("idle1", 12'h001, 1'b0, 16'd0);
    step(); chk3("idle2", 12'h002, 1'b0, 16'd0);
    step(); chk3("idle3", 12'h003, 1'b0, 16'd0);
    step(); chk3("idle4", 12'h004, 1'b0, 16'd0);

    // bne backwards: 0x010 + 1 - 4 = 0x00D
    ex_valid = 1'b1; ex_opcode = OP_BNE;
    ex_pc = 12'h010; ex_imm17 = 17'h1FFFC; ex_ne = 1'b1;
    step(); chk3("bne", 12'h00D, 1'b1, 16'd1);
    idle();
    step(); chk3("bne.w2", 12'h00E, 1'b1, 16'd1);
    step(); chk3("bne.end", 12'h00F, 1'b0, 16'd1);
    step(); chk3("bne.run", 12'h010, 1'b0, 16'd1);

    // bne not taken
    ex_valid = 1'b1; ex_opcode = OP_BNE;
    ex_pc = 12'h010; ex_imm17 = 17'h00040; ex_ne = 1'b0;
    step(); chk3("bne.nt", 12'h011, 1'b0, 16'd1);

    // j to all-ones target, then wrap
    ex_opcode = OP_J; ex_target27 = 27'h7FFFFFF;
    step(); chk3("j.max", 12'hFFF, 1'b1, 16'd2);
    idle();
    step(); chk3("j.wrap", 12'h000, 1'b1, 16'd2);
    step(); chk3("j.end", 12'h001, 1'b0, 16'd2);

    // blt at top of memory, imm=0 wraps to 0
    ex_valid = 1'b1; ex_opcode = OP_BLT;
    ex_pc = 12'hFFF; ex_imm17 = 17'h0; ex_lt = 1'b1;
    step(); chk3("blt.wrap", 12'h000, 1'b1, 16'd3);
    idle();
    step(); chk3("blt.w2", 12'h001, 1'b1, 16'd3);
    step(); chk3("blt.end", 12'h002, 1'b0, 16'd3);

    // jr with stall: redirect wins; stall ignored in window
    stall = 1'b1;
    ex_valid = 1'b1; ex_opcode = OP_JR;
    ex_rd_val = 32'h0000_0123;
    step(); chk3("jr.stall", 12'h123, 1'b1, 16'd4);
    idle();
    step(); chk3("jr.w2", 12'h124, 1'b1, 16'd4);
    step(); chk3("jr.end", 12'h125, 1'b0, 16'd4);
    step(); chk3("hold1", 12'h125, 1'b0, 16'd4);
    step(); chk3("hold2", 12'h125, 1'b0, 16'd4);
    step(); chk3("hold3", 12'h125, 1'b0, 16'd4);
    stall = 1'b0;
    step(); chk3("unhold", 12'h126, 1'b0, 16'd4);

    // bex inside flush window is ignored
    ex_valid = 1'b1; ex_opcode = OP_JAL;
    ex_target27 = 27'h0000040;
    step(); chk3("jal", 12'h040, 1'b1, 16'd5);
    ex_opcode = OP_BEX; ex_target27 = 27'h0000200;
    ex_rstatus_nz = 1'b1;
    step(); chk3("bex.fl", 12'h041, 1'b1, 16'd5);
    step(); chk3("bex.end", 12'h042, 1'b0, 16'd5);
    ex_rstatus_nz = 1'b0;
    step(); chk3("bex.nt", 12'h043, 1'b0, 16'd5);

    // unknown opcode never taken
    ex_opcode = 5'b11111; ex_ne = 1'b1; ex_lt = 1'b1;
    step(); chk3("op.bad", 12'h044, 1'b0, 16'd5);

    // bex taken in RUN, sign-extended negative target
    ex_opcode = OP_BEX; ex_rstatus_nz = 1'b1;
    ex_target27 = 27'h4000ABC;
    step(); chk3("bex.t", 12'hABC, 1'b1, 16'd6);

    // reset in first flush cycle aborts window
    reset = 1'b1;
    idle();
    step(); chk3("rst.fl", 12'h000, 1'b0, 16'd0);

    // reset beats a taken jump on the same edge
    ex_valid = 1'b1; ex_opcode = OP_J;
    ex_target27 = 27'h0000300;
    step(); chk3("rst.j", 12'h000, 1'b0, 16'd0);
    reset = 1'b0;
    idle();
    step(); chk3("rst.out", 12'h001, 1'b0, 16'd0);

    // saturation on the 4-bit counter instance
    for (int i = 0; i < 20; i++) begin
      ex_valid = 1'b1; ex_opcode = OP_J;
      ex_target27 = 27'h0000010;
      step();
      idle();
      step();
      step();
      if (i == 13) chk("sat.14", 32'(s_count), 32'd14);
      if (i == 14) chk("sat.15", 32'(s_count), 32'd15);
    end
    chk("sat.hold", 32'(s_count), 32'd15);
    chk("sat.wide", 32'(taken_count), 32'd20);
    chk("sat.pc", 32'(pc), 32'h012);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
